dmem_resp: RTL and testbench
============================

Name: dmem_resp

Overview:
- Data-memory responder for the pipelined MIPS core. It is the far end of the core's M-stage data interface: address, write data, 4-bit byte write-enable and read data.
- It accepts one request at a time and holds it for a programmable number of wait states. It then performs a byte-enabled write or a word read on an internal word array, returns a one-cycle data_ok pulse and raises stall to the core while the request is outstanding.
- It replaces the zero-latency behavioural data RAM so that memory latency can be exercised.

Parameters:
- AW, 10, word-address width; the array holds 2**AW 32-bit words.
- WAIT_CYCLES, 2, wait states between acceptance and access (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_en  input  1  request valid from the core's M stage.
- req_wen  input  4  byte write-enables; 4'b0000 means read; bit i writes byte lane i.
- req_addr  input  32  byte address; bits [1:0] are ignored.
- req_wdata  input  32  write data, already lane-aligned by the core.
- rdata  output  32  read data; valid only while data_ok=1.
- data_ok  output  1  one-cycle response pulse.
- err  output  1  out-of-range flag; valid only while data_ok=1.
- stall  output  1  core must hold its M stage while this is 1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0.
  - rdata=0, data_ok=0, err=0. stall is combinational and therefore 0.
  - Array contents are not reset.
  - Any captured request is discarded, and a pending write is never committed.
- States: IDLE, WAIT, RESP. Encodings live in the package.
- IDLE:
  - If req_en=1, capture req_wen, word index req_addr[AW+1:2], req_wdata and the range flag (req_addr[31:AW+2]!=0).
  - If WAIT_CYCLES=0, perform the access at this edge and go to RESP.
  - Otherwise load counter=WAIT_CYCLES and go to WAIT.
- WAIT:
  - counter decrements every cycle.
  - When counter==1, perform the access at this edge and go to RESP.
- Access rules:
  - Read (wen==0): rdata <= array[idx].
  - Write: each byte lane i with wen[i]=1 is replaced by wdata[8i+7:8i]; the other lanes are unchanged. rdata <= 0.
  - Out of range: no array write; rdata <= 0; err <= 1.
- RESP: data_ok=1 for exactly this cycle, then go to IDLE unconditionally. A req_en seen in RESP is not accepted; it is re-sampled in the following IDLE cycle.
- stall = (state==IDLE && req_en) || state==WAIT. stall is 0 in RESP so the core advances in that cycle.
- Latency: request seen in IDLE at cycle T gives data_ok at cycle T+1+WAIT_CYCLES. The access rate is at most one per 2+WAIT_CYCLES cycles.
- Captured request fields are frozen from acceptance to RESP. Input changes during WAIT are ignored.
- A read issued after a write to the same word returns the merged value, since accesses are strictly serialised.
- data_ok, rdata and err are registered outputs; only stall is combinational.

Decomposition:
- Package dmem_pkg holds:
  - state localparams IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
  - counter width 4;
  - lane-count constant 4.
- Sub-module bytewen_ram (parameter AW): clk, en, wen[3:0], addr[AW-1:0], wdata, rdata.
  - Synchronous read, per-lane write.
  - Instantiated once; the FSM lives in dmem_resp.

Test Plan:
- Reset mid-WAIT: WAIT_CYCLES=2; write req_wen=4'hF, addr 0x10, wdata 0xDEADBEEF; assert rst=0 one cycle after acceptance. Required: stall=0 and data_ok=0 at once, no data_ok pulse afterwards, and a later read of 0x10 does not return 0xDEADBEEF.
- Basic latency: WAIT_CYCLES=2; write 0xDEADBEEF to 0x10 with wen=4'hF, then read 0x10. Required: each data_ok arrives 3 cycles after acceptance, stall is high for 3 cycles, read rdata=0xDEADBEEF, err=0.
- Byte merge: after the basic test, write wen=4'b0100 wdata=0x00AA0000 to 0x12, then read 0x10. Required: rdata=0xDEADBEEF→0xDEAABEEF.
- Zero wait: WAIT_CYCLES=0; back-to-back reads held on req_en. Required: data_ok in every second cycle, stall high only in the accept cycle, requests never lost.
- Out of range: AW=10; write to 0x00001000, then read it. Required: data_ok with err=1 and rdata=0 for both, and word 0 remains unmodified.
- Frozen capture: change req_addr and req_wdata during WAIT. Required: the access uses the values captured at acceptance, and a req_en present during RESP is accepted only in the next IDLE cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: FSM encodings and widths.
package dmem_pkg;
    localparam int CNT_W = 4;
    localparam int LANES = 4;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;
endpackage

// File: rtl/bytewen_ram.sv
// Word array with synchronous read and per-byte-lane write enables.
module bytewen_ram
    import dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic             clk,
    input  logic             en,
    input  logic [LANES-1:0] wen,
    input  logic [AW-1:0]    addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);
    logic [LANES-1:0][7:0] r_mem [2**AW];

    // On a write cycle rdata picks up the old word; the responder masks it.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < LANES; i++) begin
                if (wen[i]) r_mem[addr][i] <= wdata[8*i +: 8];
            end
            rdata <= r_mem[addr];
        end
    end
endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states,
// byte-enabled write or word read, single-cycle data_ok pulse.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        data_ok,
    output logic        err,
    output logic        stall
);
    localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [LANES-1:0]  r_wen;
    logic [AW-1:0]     r_idx;
    logic [31:0]       r_wdata;
    logic              r_oor;
    logic              r_rd_vld, r_data_ok, r_err;

    logic              w_accept, w_access, w_live_oor, w_oor;
    logic [LANES-1:0]  w_wen;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_wdata, w_ram_q;
    logic              w_unused;

    assign w_unused   = ^req_addr[1:0];
    assign w_live_oor = |req_addr[31:AW+2];
    assign w_accept   = (r_state == IDLE) && req_en;

    // With zero wait states the access uses the live request, else the captured one.
    assign w_wen   = (r_state == IDLE) ? req_wen              : r_wen;
    assign w_idx   = (r_state == IDLE) ? req_addr[AW+1:2]     : r_idx;
    assign w_wdata = (r_state == IDLE) ? req_wdata            : r_wdata;
    assign w_oor   = (r_state == IDLE) ? w_live_oor           : r_oor;

    // Gated by rst so an edge during reset never commits a pending write.
    assign w_access = rst && ((ZERO_WAIT && w_accept) ||
                              (r_state == WAIT && r_cnt == CNT_W'(1)));

    bytewen_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .en    (w_access && !w_oor),
        .wen   (w_wen),
        .addr  (w_idx),
        .wdata (w_wdata),
        .rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_en) w_next = ZERO_WAIT ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_W'(1)) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall   = w_accept || (r_state == WAIT);
        data_ok = r_data_ok;
        err     = r_err;
        rdata   = r_rd_vld ? w_ram_q : 32'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= '0;
            r_wen     <= '0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_oor     <= 1'b0;
            r_rd_vld  <= 1'b0;
            r_data_ok <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_data_ok <= w_access;
            if (w_accept) begin
                r_wen   <= req_wen;
                r_idx   <= req_addr[AW+1:2];
                r_wdata <= req_wdata;
                r_oor   <= w_live_oor;
                r_cnt   <= CNT_W'(WAIT_CYCLES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_access) begin
                r_err    <= w_oor;
                r_rd_vld <= (w_wen == '0) && !w_oor;
            end
        end
    end
endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: one instance with two wait states, one with none,
// checked against a word-array model plus hand-built corner sequences.
module tb_dmem_resp;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        a_en, z_en;
    logic [3:0]  a_wen, z_wen;
    logic [31:0] a_addr, a_wdata, z_addr, z_wdata, a_rdata, z_rdata;
    logic        a_dok, z_dok, a_err, z_err, a_stall, z_stall;

    dmem_resp #(.AW(10), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .req_en(a_en), .req_wen(a_wen), .req_addr(a_addr),
        .req_wdata(a_wdata), .rdata(a_rdata), .data_ok(a_dok), .err(a_err), .stall(a_stall)
    );
    dmem_resp #(.AW(10), .WAIT_CYCLES(0)) u_dut_z (
        .clk(clk), .rst(rst), .req_en(z_en), .req_wen(z_wen), .req_addr(z_addr),
        .req_wdata(z_wdata), .rdata(z_rdata), .data_ok(z_dok), .err(z_err), .stall(z_stall)
    );

    typedef struct {
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_mem   [2][1024];
    bit          m_known [2][1024];
    vec_t        tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input int s, input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (s == 0) begin a_en = en; a_wen = wen; a_addr = addr; a_wdata = wdata; end
        else        begin z_en = en; z_wen = wen; z_addr = addr; z_wdata = wdata; end
    endtask

    function automatic logic f_dok(input int s);   return (s == 0) ? a_dok   : z_dok;   endfunction
    function automatic logic f_stall(input int s); return (s == 0) ? a_stall : z_stall; endfunction
    function automatic logic f_err(input int s);   return (s == 0) ? a_err   : z_err;   endfunction
    function automatic logic [31:0] f_rd(input int s); return (s == 0) ? a_rdata : z_rdata; endfunction

    function automatic void model_write(input int s, input logic [3:0] wen,
                                        input logic [31:0] addr, input logic [31:0] wdata);
        int idx;
        idx = int'(addr[11:2]);
        if (addr[31:12] != 0 || wen == 4'h0) return;
        for (int i = 0; i < 4; i++)
            if (wen[i]) m_mem[s][idx][8*i +: 8] = wdata[8*i +: 8];
        if (wen == 4'hF) m_known[s][idx] = 1'b1;
    endfunction

    // One complete request; inputs are scrambled after acceptance.
    task automatic access(input int s, input logic [3:0] wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag,
                          output logic [31:0] rd, output logic er);
        int lat, stalls, wt;
        bit got, oor, chk_rd;
        logic [31:0] exp_rd;
        wt     = (s == 0) ? 2 : 0;
        oor    = (addr[31:12] != 0);
        exp_rd = 32'd0;
        chk_rd = 1'b1;
        if (!oor && wen == 4'h0) begin
            exp_rd = m_mem[s][int'(addr[11:2])];
            chk_rd = m_known[s][int'(addr[11:2])];
        end
        @(posedge clk); #1 drive(s, 1'b1, wen, addr, wdata);
        @(negedge clk); stalls = int'(f_stall(s));
        @(posedge clk); #1 drive(s, 1'b0, 4'($urandom), $urandom, $urandom);
        lat = 0; got = 1'b0; rd = 32'd0; er = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk); lat++;
            if (f_dok(s)) begin
                got = 1'b1; rd = f_rd(s); er = f_err(s);
                chk({tag, " stall in resp"}, 32'(f_stall(s)), 32'd0);
            end else begin
                stalls += int'(f_stall(s));
            end
        end
        chk({tag, " latency"}, lat, wt + 1);
        chk({tag, " stall cycles"}, stalls, wt + 1);
        if (got) begin
            if (chk_rd) chk({tag, " rdata"}, rd, exp_rd);
            chk({tag, " err"}, 32'(er), 32'(oor));
        end
        model_write(s, wen, addr, wdata);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, ad;
        logic        er;
        int          n, pulses;
        bit          got;

        drive(0, 1'b0, 4'h0, 32'd0, 32'd0);
        drive(1, 1'b0, 4'h0, 32'd0, 32'd0);

        tbl.push_back('{4'hF, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0});
        tbl.push_back('{4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0});
        tbl.push_back('{4'h0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
        tbl.push_back('{4'h4, 32'h0000_0012, 32'h00AA_0000, 32'h0,         1'b0});
        tbl.push_back('{4'h0, 32'h0000_0010, 32'h0,         32'hDEAA_BEEF, 1'b0});
        tbl.push_back('{4'h3, 32'h0000_0010, 32'h0000_1234, 32'h0,         1'b0});
        tbl.push_back('{4'h0, 32'h0000_0013, 32'h0,         32'hDEAA_1234, 1'b0});
        tbl.push_back('{4'hF, 32'h0000_1000, 32'h1234_5678, 32'h0,         1'b1});
        tbl.push_back('{4'h0, 32'h0000_1000, 32'h0,         32'h0,         1'b1});
        tbl.push_back('{4'h0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0});

        // Reset values
        #12;
        chk("rst data_ok", 32'(a_dok), 32'd0);
        chk("rst rdata",   a_rdata,    32'd0);
        chk("rst err",     32'(a_err), 32'd0);
        chk("rst stall",   32'(a_stall), 32'd0);
        chk("rst z data_ok", 32'(z_dok), 32'd0);
        @(negedge clk); rst = 1'b1;

        // Reset while a write is waiting: it must never land
        access(0, 4'hF, 32'h10, 32'h0123_4567, "pre", rd, er);
        @(posedge clk); #1 drive(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        @(posedge clk); #1 drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("midwait rst stall",   32'(a_stall), 32'd0);
        chk("midwait rst data_ok", 32'(a_dok),   32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pulses += int'(a_dok);
        end
        chk("midwait no pulse", pulses, 0);
        access(0, 4'h0, 32'h10, 32'h0, "post rst read", rd, er);
        chk("post rst not committed", 32'(rd == 32'hDEAD_BEEF), 32'd0);

        // Table-driven basic, merge and out-of-range vectors
        foreach (tbl[k]) begin
            access(0, tbl[k].wen, tbl[k].addr, tbl[k].wdata, $sformatf("tbl%0d", k), rd, er);
            chk($sformatf("tbl%0d rdata", k), rd, tbl[k].exp_rd);
            chk($sformatf("tbl%0d err", k), 32'(er), 32'(tbl[k].exp_err));
        end

        // Frozen capture and req_en during RESP
        access(0, 4'hF, 32'h24, 32'h2424_2424, "frz pre", rd, er);
        @(posedge clk); #1 drive(0, 1'b1, 4'hF, 32'h20, 32'h1111_1111);
        @(posedge clk); #1 drive(0, 1'b0, 4'hF, 32'h24, 32'h9999_9999);
        n = 0; got = 1'b0;
        while (!got && n < 10) begin @(negedge clk); n++; got = a_dok; end
        chk("frz write latency", n, 3);
        drive(0, 1'b1, 4'h0, 32'h20, 32'h0);
        #1 chk("frz stall in resp", 32'(a_stall), 32'd0);
        n = 0; got = 1'b0;
        while (!got && n < 10) begin @(negedge clk); n++; got = a_dok; end
        chk("frz resample latency", n, 4);
        chk("frz read rdata", a_rdata, 32'h1111_1111);
        @(posedge clk); #1 drive(0, 1'b0, 4'h0, 32'h0, 32'h0);
        model_write(0, 4'hF, 32'h20, 32'h1111_1111);
        access(0, 4'h0, 32'h24, 32'h0, "frz neighbour", rd, er);

        // Zero wait states, read held on req_en
        access(1, 4'hF, 32'h40, 32'h5A5A_A5A5, "zw pre", rd, er);
        @(posedge clk); #1 drive(1, 1'b1, 4'h0, 32'h40, 32'h0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("zw data_ok %0d", i), 32'(z_dok),   32'(i % 2));
            chk($sformatf("zw stall %0d", i),   32'(z_stall), 32'(1 - i % 2));
            if (z_dok) begin
                pulses++;
                chk($sformatf("zw rdata %0d", i), z_rdata, 32'h5A5A_A5A5);
            end
        end
        chk("zw pulse count", pulses, 5);
        @(posedge clk); #1 drive(1, 1'b0, 4'h0, 32'h0, 32'h0);

        // Randomised traffic on both instances
        for (int s = 0; s < 2; s++)
            for (int w = 0; w < 16; w++)
                access(s, 4'hF, 32'h400 + 32'(4 * w), $urandom, "fill", rd, er);
        for (int i = 0; i < 200; i++) begin
            int s;
            logic [3:0] wen;
            s   = (i % 3 == 0) ? 1 : 0;
            ad  = {20'h0, 10'(10'h100 + $urandom_range(0, 15)), 2'($urandom)};
            if ($urandom_range(0, 7) == 0) ad[31:12] = 20'($urandom_range(1, 1048575));
            wen = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            access(s, wen, ad, $urandom, "rand", rd, er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
